// File: rtl/radar_sweep_ctrl.sv
// Servo sweep and scan-table controller: steps a servo through 32 angles in a
// ping-pong sweep, stores one distance per angle, exposes table/status over Avalon-MM.
module radar_sweep_ctrl #(
  parameter int PWM_PERIOD     = 1000000,
  parameter int PULSE_MIN      = 50000,
  parameter int PULSE_STEP     = 1612,
  parameter int SETTLE_PERIODS = 3,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  dist_in,
  input  logic        dist_valid,
  output logic        servo_pwm,
  input  logic [5:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);

  localparam int CNT_W = $clog2(PWM_PERIOD);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_STORE   = 2'd3;

  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_pulse_w;
  logic             r_pwm;
  logic [1:0]       r_state;
  logic [4:0]       r_idx;
  logic             r_dir;
  logic [15:0]      r_sweep_cnt;
  logic             r_enable;
  logic [3:0]       r_settle_cnt;
  logic [TO_W-1:0]  r_timeout_cnt;
  logic [9:0]       r_dist;
  logic [9:0]       r_table [0:31];
  logic [31:0]      r_readdata;

  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [23:0]      w_pulse_calc;
  logic [23:0]      w_pulse_nxt;
  logic             w_pwm_nxt;
  logic             w_ctrl_wr;
  logic             w_en_eff;
  logic             w_restart;
  logic [1:0]       w_state_nxt;
  logic [4:0]       w_idx_nxt;
  logic             w_dir_nxt;
  logic [15:0]      w_sweep_nxt;
  logic [3:0]       w_settle_nxt;
  logic [TO_W-1:0]  w_to_nxt;
  logic [9:0]       w_dist_nxt;
  logic             w_tbl_we;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_unused = ^avs_writedata[31:2];

  // Pulse width only changes at the period boundary, so a move never produces a runt pulse.
  assign w_wrap       = (r_cnt == CNT_W'(PWM_PERIOD - 1));
  assign w_cnt_nxt    = w_wrap ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
  assign w_pulse_calc = 24'(PULSE_MIN) + 24'(r_idx) * 24'(PULSE_STEP);
  assign w_pulse_nxt  = w_wrap ? w_pulse_calc : r_pulse_w;
  assign w_pwm_nxt    = (24'(w_cnt_nxt) < w_pulse_nxt);

  assign w_ctrl_wr = avs_write && (avs_address == 6'h00);
  assign w_en_eff  = w_ctrl_wr ? avs_writedata[0] : r_enable;
  assign w_restart = w_ctrl_wr && avs_writedata[1];

  // Sweep state machine; a CTRL write overrides the normal sequence in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_dir_nxt    = r_dir;
    w_sweep_nxt  = r_sweep_cnt;
    w_settle_nxt = r_settle_cnt;
    w_to_nxt     = r_timeout_cnt;
    w_dist_nxt   = r_dist;
    w_tbl_we     = 1'b0;
    if (w_restart) begin
      w_idx_nxt    = 5'd0;
      w_dir_nxt    = 1'b0;
      w_settle_nxt = 4'd0;
      w_to_nxt     = {TO_W{1'b0}};
      w_state_nxt  = w_en_eff ? S_SETTLE : S_IDLE;
    end else if (!w_en_eff) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = 4'd0;
        end
        S_SETTLE: begin
          if (w_wrap && (r_settle_cnt == 4'(SETTLE_PERIODS - 1))) begin
            w_state_nxt = S_MEASURE;
            w_to_nxt    = {TO_W{1'b0}};
          end else if (w_wrap) begin
            w_settle_nxt = r_settle_cnt + 4'd1;
          end else begin
            w_settle_nxt = r_settle_cnt;
          end
        end
        S_MEASURE: begin
          // A real echo on the expiry cycle takes priority over the no-echo marker.
          if (dist_valid) begin
            w_dist_nxt  = dist_in;
            w_state_nxt = S_STORE;
          end else if (r_timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_dist_nxt  = 10'h3FF;
            w_state_nxt = S_STORE;
          end else begin
            w_to_nxt = r_timeout_cnt + TO_W'(1);
          end
        end
        S_STORE: begin
          w_tbl_we     = 1'b1;
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = 4'd0;
          if (!r_dir && (r_idx == 5'd31)) begin
            w_dir_nxt   = 1'b1;
            w_idx_nxt   = 5'd30;
            w_sweep_nxt = r_sweep_cnt + 16'd1;
          end else if (!r_dir) begin
            w_idx_nxt = r_idx + 5'd1;
          end else if (r_idx == 5'd0) begin
            w_dir_nxt   = 1'b0;
            w_idx_nxt   = 5'd1;
            w_sweep_nxt = r_sweep_cnt + 16'd1;
          end else begin
            w_idx_nxt = r_idx - 5'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Avalon read mux.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (avs_address[5]) begin
      w_rdata = {22'h000000, r_table[avs_address[4:0]]};
    end else if (avs_address == 6'h01) begin
      w_rdata = {r_sweep_cnt, 8'h00, r_state, r_dir, r_idx};
    end else if (avs_address == 6'h00) begin
      w_rdata = {31'h0000_0000, r_enable};
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  // All state registers, including the scan table.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= {CNT_W{1'b0}};
      r_pulse_w     <= 24'(PULSE_MIN);
      r_pwm         <= 1'b0;
      r_state       <= S_IDLE;
      r_idx         <= 5'd0;
      r_dir         <= 1'b0;
      r_sweep_cnt   <= 16'd0;
      r_enable      <= 1'b0;
      r_settle_cnt  <= 4'd0;
      r_timeout_cnt <= {TO_W{1'b0}};
      r_dist        <= 10'd0;
      r_readdata    <= 32'h0000_0000;
      for (int i = 0; i < 32; i++) begin
        r_table[i] <= 10'd0;
      end
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_pulse_w     <= w_pulse_nxt;
      r_pwm         <= w_pwm_nxt;
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_dir         <= w_dir_nxt;
      r_sweep_cnt   <= w_sweep_nxt;
      r_enable      <= w_en_eff;
      r_settle_cnt  <= w_settle_nxt;
      r_timeout_cnt <= w_to_nxt;
      r_dist        <= w_dist_nxt;
      r_readdata    <= avs_read ? w_rdata : 32'h0000_0000;
      if (w_tbl_we) begin
        r_table[r_idx] <= r_dist;
      end
    end
  end

  assign servo_pwm    = r_pwm;
  assign avs_readdata = r_readdata;

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Directed testbench for radar_sweep_ctrl with shortened timing parameters.
module tb_radar_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  dist_in;
  logic        dist_valid;
  logic        servo_pwm;
  logic [5:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  radar_sweep_ctrl #(
    .PWM_PERIOD(100), .PULSE_MIN(10), .PULSE_STEP(2),
    .SETTLE_PERIODS(2), .TIMEOUT_CYCLES(500)
  ) dut (
    .clk(clk), .reset(reset), .dist_in(dist_in), .dist_valid(dist_valid),
    .servo_pwm(servo_pwm), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata)
  );

  // All bus tasks start and end on a falling edge.
  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] v);
    avs_address = a;
    avs_writedata = v;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic pulse_dist(input logic [9:0] v);
    dist_in = v;
    dist_valid = 1'b1;
    @(negedge clk);
    dist_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output logic [31:0] d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      bus_read(6'h01, d);
      if (d[7:6] == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_high(output int hi);
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (servo_pwm) hi++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int hi;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (servo_pwm !== 1'b0 || avs_readdata !== 32'h0) $display("FAIL reset_outputs pwm=%b rd=%h want 0/0", servo_pwm, avs_readdata);
    else n_pass++;
    reset = 1'b0;
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL reset_status got %h want 00000000", d);
    else n_pass++;
    bus_read(6'h20, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL reset_table0 got %h want 00000000", d);
    else n_pass++;
    bus_read(6'h3F, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL reset_table31 got %h want 00000000", d);
    else n_pass++;
    repeat (100) @(negedge clk);
    count_high(hi);
    n_total++;
    if (hi != 10) $display("FAIL idle_pwm_width got %0d want 10", hi);
    else n_pass++;
  endtask

  task automatic test_first_measure();
    logic [31:0] d;
    bit ok;
    int hi;
    bus_write(6'h00, 32'h1);
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0000_0040) $display("FAIL enable_settle got %h want 00000040", d);
    else n_pass++;
    wait_state(2'd2, 400, d, ok);
    n_total++;
    if (!ok || d !== 32'h0000_0080) $display("FAIL first_measure got %h ok=%0d want 00000080", d, ok);
    else n_pass++;
    pulse_dist(10'd123);
    bus_read(6'h20, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL store_cycle_old got %h want 00000000", d);
    else n_pass++;
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0000_0041) $display("FAIL after_store_status got %h want 00000041", d);
    else n_pass++;
    bus_read(6'h20, d);
    n_total++;
    if (d !== 32'd123) $display("FAIL table0 got %0d want 123", d);
    else n_pass++;
    repeat (100) @(negedge clk);
    count_high(hi);
    n_total++;
    if (hi != 12) $display("FAIL idx1_pwm_width got %0d want 12", hi);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    bit ok;
    wait_state(2'd2, 400, d, ok);
    n_total++;
    if (!ok || d !== 32'h0000_0081) $display("FAIL measure_idx1 got %h ok=%0d want 00000081", d, ok);
    else n_pass++;
    repeat (300) @(negedge clk);
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0000_0081) $display("FAIL still_measuring got %h want 00000081", d);
    else n_pass++;
    wait_state(2'd1, 600, d, ok);
    n_total++;
    if (!ok || d !== 32'h0000_0042) $display("FAIL timeout_advance got %h ok=%0d want 00000042", d, ok);
    else n_pass++;
    bus_read(6'h21, d);
    n_total++;
    if (d !== 32'h0000_03FF) $display("FAIL timeout_value got %h want 000003ff", d);
    else n_pass++;
  endtask

  task automatic test_expiry_race();
    logic [31:0] d;
    bit ok;
    bit sync_ok;
    int n;
    wait_state(2'd2, 400, d, ok);
    n_total++;
    if (!ok || d !== 32'h0000_0082) $display("FAIL measure_idx2 got %h ok=%0d want 00000082", d, ok);
    else n_pass++;
    // Align to the second period start inside MEASURE (timeout count 100).
    n = 0;
    while (servo_pwm !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    sync_ok = (n < 200);
    n = 0;
    while (servo_pwm !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    sync_ok = sync_ok && (n < 200);
    n_total++;
    if (!sync_ok) $display("FAIL pwm_sync got timeout want edge");
    else n_pass++;
    repeat (399) @(negedge clk);
    pulse_dist(10'd77);
    @(negedge clk);
    bus_read(6'h22, d);
    n_total++;
    if (d !== 32'd77) $display("FAIL expiry_race got %h want 0000004d", d);
    else n_pass++;
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0000_0043) $display("FAIL after_race_status got %h want 00000043", d);
    else n_pass++;
  endtask

  task automatic test_full_sweep();
    logic [31:0] d;
    logic [31:0] exp_s;
    bit ok;
    logic [4:0]  e_idx = 5'd3;
    logic        e_dir = 1'b0;
    logic [15:0] e_sweep = 16'd0;
    for (int step = 0; step < 60; step++) begin
      wait_state(2'd2, 400, d, ok);
      exp_s = {e_sweep, 8'h00, 2'd2, e_dir, e_idx};
      n_total++;
      if (!ok || d !== exp_s) $display("FAIL sweep_step%0d got %h ok=%0d want %h", step, d, ok, exp_s);
      else n_pass++;
      pulse_dist({5'd0, e_idx});
      if (!e_dir && e_idx == 5'd31) begin
        e_dir = 1'b1; e_idx = 5'd30; e_sweep = e_sweep + 16'd1;
      end else if (!e_dir) begin
        e_idx = e_idx + 5'd1;
      end else if (e_idx == 5'd0) begin
        e_dir = 1'b0; e_idx = 5'd1; e_sweep = e_sweep + 16'd1;
      end else begin
        e_idx = e_idx - 5'd1;
      end
    end
    @(negedge clk);
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0002_0041) $display("FAIL sweep_end_status got %h want 00020041", d);
    else n_pass++;
  endtask

  task automatic test_disable();
    logic [31:0] d;
    bus_write(6'h00, 32'h0);
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0002_0001) $display("FAIL disable_idle got %h want 00020001", d);
    else n_pass++;
    pulse_dist(10'd999);
    repeat (250) @(negedge clk);
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0002_0001) $display("FAIL idle_hold got %h want 00020001", d);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      bus_read(6'h20 + 6'(i), d);
      n_total++;
      if (d !== 32'(i)) $display("FAIL table%0d got %0d want %0d", i, d, i);
      else n_pass++;
    end
    bus_read(6'h10, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL unmapped got %h want 00000000", d);
    else n_pass++;
  endtask

  task automatic test_restart();
    logic [31:0] d;
    bus_write(6'h00, 32'h2);
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0002_0000) $display("FAIL restart_idle got %h want 00020000", d);
    else n_pass++;
    bus_write(6'h00, 32'h3);
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0002_0040) $display("FAIL restart_enable got %h want 00020040", d);
    else n_pass++;
    bus_write(6'h01, 32'hFFFF_FFFF);
    bus_write(6'h25, 32'h0000_0000);
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0002_0040) $display("FAIL status_write_ignored got %h want 00020040", d);
    else n_pass++;
    bus_read(6'h25, d);
    n_total++;
    if (d !== 32'd5) $display("FAIL table_write_ignored got %0d want 5", d);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(6'h3F, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL mid_reset_table31 got %h want 00000000", d);
    else n_pass++;
    bus_read(6'h01, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL mid_reset_status got %h want 00000000", d);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    dist_in = 10'd0;
    dist_valid = 1'b0;
    avs_address = 6'd0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = 32'd0;
    @(negedge clk);
    test_reset();
    test_first_measure();
    test_timeout();
    test_expiry_race();
    test_full_sweep();
    test_disable();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/radar_sweep_ctrl.md
# radar_sweep_ctrl

Servo sweep and scan-table controller for the 2D radar. Sits directly downstream of the ultrasonic telemeter: it consumes each completed distance measurement, steps a hobby servo through 32 angular positions in a ping-pong sweep, and stores one distance per angle in a scan table. The Nios II reads the table and control/status registers over an Avalon-MM slave to draw the radar display on VGA.

## Interface
- PWM_PERIOD, 1000000: servo PWM period in clk cycles (20 ms at 50 MHz)
- PULSE_MIN, 50000: high time at angle index 0 (1 ms)
- PULSE_STEP, 1612: high-time increment per angle index
- SETTLE_PERIODS, 3: full PWM periods to wait after a move before accepting a measurement (1..15)
- TIMEOUT_CYCLES, 2500000: max wait for a measurement after settling
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- dist_in  in  10  distance from telemeter, cm
- dist_valid  in  1  one-cycle strobe: dist_in holds a new measurement
- servo_pwm  out  1  servo control pulse
- avs_address  in  6  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid 1 cycle after avs_read

## Operation
- Register map: 0x00 CTRL (bit0 enable, bit1 restart, write-1, self-clearing); 0x01 STATUS (bits4:0 idx, bit5 dir 0=up/1=down, bits7:6 state, bits31:16 sweep_count); 0x20..0x3F table[0..31], bits9:0 distance, bits31:10 zero. Other addresses read 0; writes to STATUS/table ignored.
- States: IDLE(0), SETTLE(1), MEASURE(2), STORE(3).
- IDLE: enable=1 -> SETTLE, settle counter cleared.
- SETTLE: counts PWM period wraps; after SETTLE_PERIODS wraps -> MEASURE, timeout counter cleared.
- MEASURE: dist_valid -> latch dist_in, -> STORE. Timeout counter reaching TIMEOUT_CYCLES-1 -> latch 10'h3FF (no echo), -> STORE. dist_valid in same cycle as expiry: dist_in wins.
- STORE: write latched value to table[idx]; advance idx: dir up and idx<31 -> idx+1; idx=31 -> dir down, idx 30, sweep_count+1; dir down and idx>0 -> idx-1; idx=0 -> dir up, idx 1, sweep_count+1. sweep_count is 16-bit, wraps. -> SETTLE.
- dist_valid outside MEASURE ignored.
- enable cleared in any state: next cycle IDLE; idx, dir, table, sweep_count kept; PWM keeps current pulse width.
- restart: idx=0, dir=up, settle/timeout counters cleared, state -> SETTLE if enable (written same word) else IDLE; table and sweep_count kept.
- PWM: period counter 0..PWM_PERIOD-1 free-running; servo_pwm = (cnt < pulse_w). pulse_w = PULSE_MIN + idx*PULSE_STEP (24-bit), reloaded only when cnt wraps to 0, so no glitch pulses.

## Timing
- Reset values: servo_pwm 0, avs_readdata 0, state IDLE, idx 0, dir up, sweep_count 0, enable 0, all table entries 0, pulse_w PULSE_MIN, PWM counter 0.
- servo_pwm high from cnt=0 for exactly pulse_w cycles each period, also in IDLE.
- Read latency 1 cycle, fixed; no waitrequest. Read of table[idx] in the cycle STORE writes it returns old value.
- CTRL write takes effect the following cycle.
- Step time (MEASURE entry to next MEASURE entry) ≥ SETTLE_PERIODS*PWM_PERIOD; settle count begins at the first wrap after entering SETTLE.
- Reset mid-operation: all state to reset values next edge, table zeroed.

## Test plan
- Bench params PWM_PERIOD=100, PULSE_MIN=10, PULSE_STEP=2, SETTLE_PERIODS=2, TIMEOUT_CYCLES=500.
- Reset then idle: servo_pwm high 10 of every 100 cycles; STATUS reads 0; table reads 0.
- Enable, pulse dist_valid with dist_in=123 in MEASURE -> table[0]=123, STATUS idx=1, pulse width 12 from next period.
- No dist_valid for 500 cycles in MEASURE -> table[idx]=0x3FF; dist_valid on the expiry cycle with 77 -> 77 stored.
- Run full sweep with dist=idx -> table[i]=i, at idx 31 dir flips, idx 30 next, sweep_count=1; back at 0 sweep_count=2.
- Clear enable mid-SETTLE -> IDLE next cycle, idx held, dist_valid ignored; restart write -> idx 0, dir up, table unchanged; read unmapped 0x10 -> 0.
